l1_pmem_responder: RTL and testbench

- Line-granular physical-memory responder on the pmem side of the L1 cache datapath/controller.
- Accepts one 128-bit line read or write at a time, waits a programmable latency, then returns data or commits the write and pulses pmem_resp.
- Used as the synthesizable backing store/memory model under the L1 in integration and as the stub for the later L2 slot.

---
 rtl/l1_pmem_responder.sv | 166 ++++++++++++++++
 tb/tb_l1_pmem_responder.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_pmem_responder.sv
`timescale 1ns/1ps
// l1_pmem_responder
// Line-granular physical-memory responder that sits under the L1 cache. It
// serves one 128-bit line read or write at a time, waits LATENCY cycles from
// the cycle the request is first seen, then pulses pmem_resp for one cycle.
//
// Handshake: the requester raises pmem_read or pmem_write together with
// pmem_address/pmem_wdata and holds all of them stable until the cycle in
// which pmem_resp=1. It drops the request in the following cycle. A request
// still high in that cycle is accepted as a new request.
//
// Ports:
//   clk          system clock, all state updates on the rising edge
//   reset        synchronous, active-high reset
//   pmem_read    line read request
//   pmem_write   line write request (wins if both are high)
//   pmem_address byte address, bits [LINE_BITS+3:4] select the line
//   pmem_wdata   write line
//   pmem_rdata   read line, meaningful only while pmem_resp=1 on a read
//   pmem_resp    one-cycle completion pulse
//   proto_err    sticky protocol-violation flag, cleared only by reset
//
// The FSM state is the internal signal 'state' (IDLE/BUSY/RESP).
module l1_pmem_responder #(
    parameter int LATENCY   = 4,
    parameter int LINE_BITS = 12
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         pmem_read,
    input  logic         pmem_write,
    input  logic [15:0]  pmem_address,
    input  logic [127:0] pmem_wdata,
    output logic [127:0] pmem_rdata,
    output logic         pmem_resp,
    output logic         proto_err
);

    localparam int         DEPTH  = 1 << LINE_BITS;
    localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_next;
    logic [7:0] cnt, cnt_next;

    // Request captured at acceptance.
    logic                 op_write;
    logic [1:0]           req_lat;
    logic [11:0]          addr_lat;
    logic [127:0]         wdata_lat;

    logic [127:0]         mem [DEPTH];

    logic                 req;
    logic                 accept;
    logic                 load_rdata;
    logic                 violation;
    logic                 changed;
    logic [LINE_BITS-1:0] addr_idx;
    logic [LINE_BITS-1:0] line_idx;
    logic [LINE_BITS-1:0] rdata_idx;

    // Byte-offset bits never select anything.
    logic unused_offset_bits;
    assign unused_offset_bits = ^pmem_address[3:0];

    assign req       = pmem_read | pmem_write;
    assign addr_idx  = pmem_address[LINE_BITS+3:4];
    assign line_idx  = addr_lat[LINE_BITS-1:0];
    assign pmem_resp = (state == RESP);

    // Anything the requester must hold stable that moved after acceptance.
    // wdata only matters for writes, so a read is free to drive anything there.
    assign changed = ({pmem_read, pmem_write} != req_lat) ||
                     (pmem_address[15:4] != addr_lat) ||
                     (op_write && (pmem_wdata != wdata_lat));

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        load_rdata = 1'b0;
        violation  = 1'b0;
        rdata_idx  = line_idx;
        case (state)
            IDLE: begin
                if (req) begin
                    accept    = 1'b1;
                    cnt_next  = LAT_M1;
                    rdata_idx = addr_idx;
                    if (LAT_M1 == 8'd0) begin
                        state_next = RESP;
                        load_rdata = !pmem_write;
                    end else begin
                        state_next = BUSY;
                    end
                end
            end
            BUSY: begin
                // A withdrawn request also shows up as 'changed'.
                violation = changed;
                if (!req) begin
                    state_next = IDLE;
                    cnt_next   = 8'd0;
                end else begin
                    cnt_next = cnt - 8'd1;
                    if (cnt == 8'd1) begin
                        state_next = RESP;
                        load_rdata = !op_write;
                    end
                end
            end
            RESP: begin
                violation  = changed;
                state_next = IDLE;
                cnt_next   = 8'd0;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 8'd0;
            pmem_rdata <= '0;
            proto_err  <= 1'b0;
            op_write   <= 1'b0;
            req_lat    <= 2'b00;
            addr_lat   <= '0;
            wdata_lat  <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                op_write  <= pmem_write;
                req_lat   <= {pmem_read, pmem_write};
                addr_lat  <= pmem_address[15:4];
                wdata_lat <= pmem_wdata;
            end
            // Loaded on the edge entering RESP so the line is valid with pmem_resp.
            if (load_rdata) begin
                pmem_rdata <= mem[rdata_idx];
            end
            if (violation || (accept && pmem_read && pmem_write)) begin
                proto_err <= 1'b1;
            end
        end
    end

    // Storage has no reset; a reset landing in RESP must not commit the write.
    always_ff @(posedge clk) begin
        if (state == RESP && op_write && !reset) begin
            mem[line_idx] <= wdata_lat;
        end
    end

endmodule

// File: tb/tb_l1_pmem_responder.sv
`timescale 1ns/1ps
module tb_l1_pmem_responder;

    logic         clk = 1'b0;
    logic         reset = 1'b1;

    // LATENCY=4 instance
    logic         pmem_read = 1'b0;
    logic         pmem_write = 1'b0;
    logic [15:0]  pmem_address = '0;
    logic [127:0] pmem_wdata = '0;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;
    logic         proto_err;

    // LATENCY=1 instance
    logic         r1 = 1'b0;
    logic         w1 = 1'b0;
    logic [15:0]  a1 = '0;
    logic [127:0] wd1 = '0;
    logic [127:0] rdata1;
    logic         resp1;
    logic         err1;

    int n_cmp = 0;
    int n_bad = 0;
    int resp_pulses = 0;

    always #5 clk = ~clk;

    l1_pmem_responder #(.LATENCY(4), .LINE_BITS(12)) dut (
        .clk(clk), .reset(reset),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp), .proto_err(proto_err)
    );

    l1_pmem_responder #(.LATENCY(1), .LINE_BITS(12)) dut1 (
        .clk(clk), .reset(reset),
        .pmem_read(r1), .pmem_write(w1),
        .pmem_address(a1), .pmem_wdata(wd1),
        .pmem_rdata(rdata1), .pmem_resp(resp1), .proto_err(err1)
    );

    always @(negedge clk) begin
        if (pmem_resp) resp_pulses++;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        pmem_read = 1'b0;
        pmem_write = 1'b0;
        r1 = 1'b0;
        w1 = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Drives one request from cycle 0, returns the cycle of pmem_resp (-1 on
    // timeout) and the rdata seen in that cycle, then drops the request.
    task automatic do_req(input logic rd, input logic wr, input logic [15:0] addr,
                          input logic [127:0] wd, output logic [127:0] rdata, output int rcyc);
        @(posedge clk); #1;
        pmem_read = rd;
        pmem_write = wr;
        pmem_address = addr;
        pmem_wdata = wd;
        rcyc = -1;
        rdata = '0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (pmem_resp) begin
                rcyc = c;
                rdata = pmem_rdata;
                break;
            end
        end
        @(posedge clk); #1;
        pmem_read = 1'b0;
        pmem_write = 1'b0;
    endtask

    typedef struct {
        logic         rd;
        logic         wr;
        logic [15:0]  addr;
        logic [127:0] wd;
        logic [127:0] exp_rdata;
    } vec_t;

    localparam logic [127:0] D_DEAD = 128'hDEADBEEF_CAFEF00D_01234567_00000001;
    localparam logic [127:0] D_X    = 128'h11112222_33334444_55556666_77778888;
    localparam logic [127:0] D_Y    = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
    localparam logic [127:0] D_Z    = 128'h0BADC0DE_12345678_9ABCDEF0_FEEDFACE;
    localparam logic [127:0] D_W    = 128'h00000000_FFFFFFFF_00000000_13579BDF;
    localparam logic [127:0] D_A    = 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_AAAAAAA1;
    localparam logic [127:0] D_B    = 128'hBBBBBBBB_BBBBBBBB_BBBBBBBB_BBBBBBB2;

    vec_t tbl [7];
    logic [127:0] model_mem [int];

    initial begin
        logic [127:0] rd_data;
        logic [127:0] exp;
        logic [127:0] last_rdata;
        logic [11:0]  line;
        logic [15:0]  addr;
        logic [127:0] wd;
        logic         is_wr;
        int           rcyc;
        int           pulses_before;

        // Writes expect pmem_rdata to still hold the previous read line.
        tbl[0] = '{1'b1, 1'b0, 16'h1230, 128'h0, 128'h0};
        tbl[1] = '{1'b0, 1'b1, 16'h1230, D_DEAD, 128'h0};
        tbl[2] = '{1'b1, 1'b0, 16'h123E, 128'h0, D_DEAD};
        tbl[3] = '{1'b0, 1'b1, 16'h0050, D_X,    D_DEAD};
        tbl[4] = '{1'b1, 1'b0, 16'h0058, 128'h0, D_X};
        tbl[5] = '{1'b0, 1'b1, 16'h4560, D_Y,    D_X};
        tbl[6] = '{1'b1, 1'b0, 16'h4560, 128'h0, D_Y};

        // Reset state
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_resp", 128'(pmem_resp), 128'(1'b0));
        check("reset_rdata", pmem_rdata, 128'h0);
        check("reset_err", 128'(proto_err), 128'(1'b0));

        // Table-driven transactions, LATENCY=4
        pulses_before = resp_pulses;
        for (int i = 0; i < 7; i++) begin
            do_req(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wd, rd_data, rcyc);
            check($sformatf("tbl%0d_latency", i), 128'(rcyc), 128'(4));
            check($sformatf("tbl%0d_rdata", i), rd_data, tbl[i].exp_rdata);
        end
        check("tbl_resp_pulses", 128'(resp_pulses - pulses_before), 128'(7));
        check("tbl_err", 128'(proto_err), 128'(1'b0));

        // LATENCY=1: read held across responses gives resp in cycles 1 and 3
        @(posedge clk); #1;
        r1 = 1'b1;
        a1 = 16'h0000;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("lat1_resp_c%0d", c), 128'(resp1), 128'((c == 1) || (c == 3)));
        end
        @(posedge clk); #1;
        r1 = 1'b0;
        @(negedge clk);
        check("lat1_resp_c4", 128'(resp1), 128'(1'b0));
        check("lat1_rdata", rdata1, 128'h0);
        check("lat1_err", 128'(err1), 128'(1'b0));

        // Address changed in cycle 2 of a write: commit to the latched line
        @(posedge clk); #1;
        pmem_write = 1'b1;
        pmem_address = 16'h1230;
        pmem_wdata = D_Z;
        @(posedge clk); #1;
        @(posedge clk); #1;
        pmem_address = 16'h4560;
        @(negedge clk);
        check("addrchg_err_c2", 128'(proto_err), 128'(1'b0));
        @(negedge clk);
        check("addrchg_err_c3", 128'(proto_err), 128'(1'b1));
        check("addrchg_resp_c3", 128'(pmem_resp), 128'(1'b0));
        @(negedge clk);
        check("addrchg_resp_c4", 128'(pmem_resp), 128'(1'b1));
        @(posedge clk); #1;
        pmem_write = 1'b0;
        do_req(1'b1, 1'b0, 16'h1230, 128'h0, rd_data, rcyc);
        check("addrchg_line123", rd_data, D_Z);
        do_req(1'b1, 1'b0, 16'h4560, 128'h0, rd_data, rcyc);
        check("addrchg_line456", rd_data, D_Y);
        check("addrchg_err_sticky", 128'(proto_err), 128'(1'b1));

        // Withdrawn write during BUSY: no response, no commit, error flagged
        do_reset();
        @(posedge clk); #1;
        pmem_write = 1'b1;
        pmem_address = 16'h1230;
        pmem_wdata = D_W;
        @(posedge clk); #1;
        @(posedge clk); #1;
        pmem_write = 1'b0;
        pulses_before = resp_pulses;
        @(negedge clk);
        @(negedge clk);
        check("withdraw_err", 128'(proto_err), 128'(1'b1));
        repeat (4) @(negedge clk);
        check("withdraw_no_resp", 128'(resp_pulses - pulses_before), 128'(0));
        do_req(1'b1, 1'b0, 16'h1230, 128'h0, rd_data, rcyc);
        check("withdraw_no_commit", rd_data, D_Z);

        // Read and write both high: treated as a write
        do_reset();
        check("both_err_pre", 128'(proto_err), 128'(1'b0));
        do_req(1'b1, 1'b1, 16'h0010, D_W, rd_data, rcyc);
        check("both_latency", 128'(rcyc), 128'(4));
        check("both_err", 128'(proto_err), 128'(1'b1));
        do_req(1'b1, 1'b0, 16'h0010, 128'h0, rd_data, rcyc);
        check("both_readback", rd_data, D_W);

        // Reset in cycle 2 of a write drops it
        do_reset();
        do_req(1'b0, 1'b1, 16'h0020, D_A, rd_data, rcyc);
        do_req(1'b1, 1'b0, 16'h0020, 128'h0, rd_data, rcyc);
        check("rst_pre_read", rd_data, D_A);
        pulses_before = resp_pulses;
        @(posedge clk); #1;
        pmem_write = 1'b1;
        pmem_address = 16'h0020;
        pmem_wdata = D_B;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        pmem_write = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_resp", 128'(pmem_resp), 128'(1'b0));
        check("rst_rdata", pmem_rdata, 128'h0);
        check("rst_err", 128'(proto_err), 128'(1'b0));
        repeat (5) @(negedge clk);
        check("rst_no_resp", 128'(resp_pulses - pulses_before), 128'(0));
        do_req(1'b1, 1'b0, 16'h0020, 128'h0, rd_data, rcyc);
        check("rst_old_contents", rd_data, D_A);

        // Randomized traffic against a line-indexed array model
        do_reset();
        last_rdata = '0;
        for (int i = 0; i < 60; i++) begin
            is_wr = 1'($urandom_range(0, 1));
            line = 12'h800 + 12'($urandom_range(0, 7));
            addr = {line, 4'($urandom_range(0, 15))};
            wd = {$urandom, $urandom, $urandom, $urandom};
            do_req(!is_wr, is_wr, addr, wd, rd_data, rcyc);
            check($sformatf("rnd%0d_latency", i), 128'(rcyc), 128'(4));
            if (is_wr) begin
                check($sformatf("rnd%0d_wr_hold", i), rd_data, last_rdata);
                model_mem[int'(line)] = wd;
            end else begin
                exp = model_mem.exists(int'(line)) ? model_mem[int'(line)] : 128'h0;
                check($sformatf("rnd%0d_rdata", i), rd_data, exp);
                last_rdata = exp;
            end
        end
        check("rnd_err", 128'(proto_err), 128'(1'b0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
